// File: rtl/uart_host_pkg.sv
// Shared definitions for the UART host command generator:
// command codes, command types, byte counts and frame states.
package uart_host_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  typedef enum logic [1:0] {
    CT_RF_WR   = 2'd0,
    CT_RF_RD   = 2'd1,
    CT_ALU_OP  = 2'd2,
    CT_ALU_NOP = 2'd3
  } cmd_type_e;

  localparam logic [2:0] NB_RF_WR   = 3'd3;
  localparam logic [2:0] NB_RF_RD   = 3'd2;
  localparam logic [2:0] NB_ALU_OP  = 3'd4;
  localparam logic [2:0] NB_ALU_NOP = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_GAP
  } frame_st_e;

  function automatic logic [2:0] cmd_nbytes(input logic [1:0] t);
    logic [2:0] n;
    n = NB_RF_WR;
    case (t)
      CT_RF_WR:   n = NB_RF_WR;
      CT_RF_RD:   n = NB_RF_RD;
      CT_ALU_OP:  n = NB_ALU_OP;
      CT_ALU_NOP: n = NB_ALU_NOP;
      default:    n = NB_RF_WR;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] cmd_byte(
    input logic [1:0] t,
    input logic [1:0] i,
    input logic [3:0] addr,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [3:0] fun
  );
    logic [7:0] ad;
    logic [7:0] fn;
    logic [7:0] r;
    ad = {4'h0, addr};
    fn = {4'h0, fun};
    r  = 8'h00;
    case (t)
      CT_RF_WR:   r = (i == 2'd0) ? CMD_RF_WR :
                      (i == 2'd1) ? ad : a;
      CT_RF_RD:   r = (i == 2'd0) ? CMD_RF_RD : ad;
      CT_ALU_OP: begin
        case (i)
          2'd0:    r = CMD_ALU_OP;
          2'd1:    r = a;
          2'd2:    r = b;
          default: r = fn;
        endcase
      end
      CT_ALU_NOP: r = (i == 2'd0) ? CMD_ALU_NOP : fn;
      default:    r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_host_bit_ser.sv
// Serializes one byte per load as start/data/parity/stop/gap bits;
// owns the baud down-counter and bit index.
module uart_host_bit_ser
  import uart_host_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_W     = 16,
  parameter int IFG_BITS   = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] byte_i,
  input  logic                  par_en_i,
  input  logic                  par_typ_i,
  input  logic [BAUD_W-1:0]     baud_div_i,
  output logic                  tx_o,
  output logic                  frame_done_o
);

  localparam int MAXB = (DATA_WIDTH > IFG_BITS) ? DATA_WIDTH : IFG_BITS;
  localparam int IW   = $clog2(MAXB + 1);

  frame_st_e             st_q, st_d;
  logic [BAUD_W-1:0]     cnt_q, cnt_d;
  logic [BAUD_W-1:0]     div_q, div_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  par_q, par_d;
  logic                  pen_q, pen_d;
  logic                  tick, fend, do_load;

  assign tick         = (cnt_q == '0);
  assign frame_done_o = fend;

  always_comb begin
    st_d    = st_q;
    cnt_d   = tick ? div_q : cnt_q - 1'b1;
    div_d   = div_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    par_d   = par_q;
    pen_d   = pen_q;
    fend    = 1'b0;
    do_load = 1'b0;
    tx_o    = 1'b1;
    unique case (st_q)
      ST_IDLE: cnt_d = cnt_q;
      ST_START: begin
        tx_o  = 1'b0;
        idx_d = '0;
        if (tick) st_d = ST_DATA;
      end
      ST_DATA: begin
        tx_o = sh_q[0];
        if (tick) begin
          sh_d  = sh_q >> 1;
          idx_d = idx_q + 1'b1;
          if (idx_q == IW'(DATA_WIDTH - 1))
            st_d = pen_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        tx_o = par_q;
        if (tick) st_d = ST_STOP;
      end
      ST_STOP: begin
        if (tick) begin
          idx_d = '0;
          if (IFG_BITS > 0) st_d = ST_GAP;
          else              fend = 1'b1;
        end
      end
      ST_GAP: begin
        if (tick) begin
          idx_d = idx_q + 1'b1;
          if (int'(idx_q) == IFG_BITS - 1) fend = 1'b1;
        end
      end
      default: st_d = ST_IDLE;
    endcase
    if (fend) st_d = ST_IDLE;
    // a new byte may chain straight from the last bit-time of the previous one
    do_load = load_i && ((st_q == ST_IDLE) || fend);
    if (do_load) begin
      st_d  = ST_START;
      div_d = (baud_div_i == '0) ? '0 : baud_div_i - 1'b1;
      cnt_d = div_d;
      idx_d = '0;
      sh_d  = byte_i;
      pen_d = par_en_i;
      par_d = par_typ_i ? ~^byte_i : ^byte_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q  <= ST_IDLE;
      cnt_q <= '0;
      div_q <= '0;
      idx_q <= '0;
      sh_q  <= '0;
      par_q <= 1'b0;
      pen_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      idx_q <= idx_d;
      sh_q  <= sh_d;
      par_q <= par_d;
      pen_q <= pen_d;
    end
  end

endmodule

// File: rtl/uart_host_cmd_gen.sv
// Host-side command generator: latches one command per handshake and
// streams its byte sequence as UART frames on tx_out.
module uart_host_cmd_gen
  import uart_host_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_W     = 16,
  parameter int IFG_BITS   = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_type,
  input  logic [3:0]        cmd_addr,
  input  logic [7:0]        cmd_op_a,
  input  logic [7:0]        cmd_op_b,
  input  logic [3:0]        cmd_fun,
  input  logic              par_en,
  input  logic              par_typ,
  input  logic [BAUD_W-1:0] baud_div,
  output logic              tx_out,
  output logic              busy,
  output logic              cmd_done
);

  logic              act_q, done_q;
  logic [1:0]        idx_q, nxt_idx;
  logic [1:0]        typ_q;
  logic [3:0]        addr_q, fun_q;
  logic [7:0]        a_q, b_q;
  logic              pen_q, ptyp_q;
  logic [BAUD_W-1:0] div_q;
  logic              accept, last, load, fdone;
  logic [7:0]        ser_byte;

  assign accept  = cmd_valid && !act_q;
  assign nxt_idx = idx_q + 2'd1;
  assign last    = ({1'b0, idx_q} == cmd_nbytes(typ_q) - 3'd1);
  assign load    = accept || (fdone && !last);

  // the first byte comes from the live inputs, the rest from the latch
  assign ser_byte = accept
    ? cmd_byte(cmd_type, 2'd0, cmd_addr, cmd_op_a, cmd_op_b, cmd_fun)
    : cmd_byte(typ_q, nxt_idx, addr_q, a_q, b_q, fun_q);

  assign cmd_ready = !act_q;
  assign busy      = act_q;
  assign cmd_done  = done_q;

  uart_host_bit_ser #(
    .DATA_WIDTH(DATA_WIDTH),
    .BAUD_W    (BAUD_W),
    .IFG_BITS  (IFG_BITS)
  ) u_ser (
    .clk_i       (CLK),
    .rst_ni      (RST),
    .load_i      (load),
    .byte_i      (DATA_WIDTH'(ser_byte)),
    .par_en_i    (accept ? par_en : pen_q),
    .par_typ_i   (accept ? par_typ : ptyp_q),
    .baud_div_i  (accept ? baud_div : div_q),
    .tx_o        (tx_out),
    .frame_done_o(fdone)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      act_q  <= 1'b0;
      done_q <= 1'b0;
      idx_q  <= '0;
      typ_q  <= '0;
      addr_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      fun_q  <= '0;
      pen_q  <= 1'b0;
      ptyp_q <= 1'b0;
      div_q  <= '0;
    end else begin
      done_q <= fdone && last;
      if (accept) begin
        act_q  <= 1'b1;
        idx_q  <= '0;
        typ_q  <= cmd_type;
        addr_q <= cmd_addr;
        a_q    <= cmd_op_a;
        b_q    <= cmd_op_b;
        fun_q  <= cmd_fun;
        pen_q  <= par_en;
        ptyp_q <= par_typ;
        div_q  <= baud_div;
      end else if (fdone) begin
        if (last) begin
          act_q <= 1'b0;
          idx_q <= '0;
        end else begin
          idx_q <= nxt_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_host_cmd_gen.sv
// Self-checking bench for uart_host_cmd_gen: expected line waveform is
// built from the byte list and frame rules, compared cycle by cycle.
module tb_uart_host_cmd_gen;

  localparam int IFG = 1;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_type = '0;
  logic [3:0]  cmd_addr = '0;
  logic [7:0]  cmd_op_a = '0;
  logic [7:0]  cmd_op_b = '0;
  logic [3:0]  cmd_fun = '0;
  logic        par_en = 1'b0;
  logic        par_typ = 1'b0;
  logic [15:0] baud_div = 16'd1;
  logic        tx_out, busy, cmd_done;

  int checks = 0;
  int passed = 0;
  logic exp_q[$];

  uart_host_cmd_gen #(
    .DATA_WIDTH(8),
    .BAUD_W    (16),
    .IFG_BITS  (IFG)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_type (cmd_type),
    .cmd_addr (cmd_addr),
    .cmd_op_a (cmd_op_a),
    .cmd_op_b (cmd_op_b),
    .cmd_fun  (cmd_fun),
    .par_en   (par_en),
    .par_typ  (par_typ),
    .baud_div (baud_div),
    .tx_out   (tx_out),
    .busy     (busy),
    .cmd_done (cmd_done)
  );

  always #5 CLK = ~CLK;

  task automatic build_exp(input logic [1:0] t, input logic [3:0] ad,
                           input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] fn, input logic pe,
                           input logic pt, input int div);
    logic [7:0] bl[$];
    logic       bits[$];
    int         d;
    d = (div == 0) ? 1 : div;
    case (t)
      2'd0: begin bl.push_back(8'hAA); bl.push_back({4'h0, ad}); bl.push_back(a); end
      2'd1: begin bl.push_back(8'hBB); bl.push_back({4'h0, ad}); end
      2'd2: begin bl.push_back(8'hCC); bl.push_back(a); bl.push_back(b);
                  bl.push_back({4'h0, fn}); end
      default: begin bl.push_back(8'hDD); bl.push_back({4'h0, fn}); end
    endcase
    foreach (bl[k]) begin
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(bl[k][i]);
      if (pe) bits.push_back(pt ? ~^bl[k] : ^bl[k]);
      bits.push_back(1'b1);
      for (int g = 0; g < IFG; g++) bits.push_back(1'b1);
    end
    exp_q.delete();
    foreach (bits[k])
      for (int r = 0; r < d; r++) exp_q.push_back(bits[k]);
  endtask

  // Entered #1 after the accept edge; returns #1 after the cmd_done edge.
  task automatic check_stream(input string nm, input logic [1:0] t,
                              input logic [3:0] ad, input logic [7:0] a,
                              input logic [7:0] b, input logic [3:0] fn,
                              input logic pe, input logic pt, input int div,
                              input bit scramble);
    int n, bad_w, bad_r, bad_d, first;
    build_exp(t, ad, a, b, fn, pe, pt, div);
    n = exp_q.size();
    bad_w = 0; bad_r = 0; bad_d = 0; first = -1;
    for (int i = 0; i < n; i++) begin
      if (tx_out !== exp_q[i]) begin
        bad_w++;
        if (first < 0) first = i;
      end
      if (cmd_ready !== 1'b0 || busy !== 1'b1) bad_r++;
      if (cmd_done !== 1'b0) bad_d++;
      if (scramble) begin
        @(negedge CLK);
        cmd_type = 2'($urandom); cmd_addr = 4'($urandom);
        cmd_op_a = 8'($urandom); cmd_op_b = 8'($urandom);
        cmd_fun = 4'($urandom); par_en = 1'($urandom);
        par_typ = 1'($urandom); baud_div = 16'($urandom_range(0, 7));
      end
      @(posedge CLK); #1;
    end
    checks++;
    if (bad_w != 0)
      $display("FAIL %s wave: %0d bad of %0d cycles, first at cycle %0d", nm, bad_w, n, first);
    else passed++;
    checks++;
    if (bad_r != 0)
      $display("FAIL %s busy: ready/busy wrong in %0d cycles, required ready=0 busy=1", nm, bad_r);
    else passed++;
    checks++;
    if (bad_d != 0)
      $display("FAIL %s early_done: cmd_done high in %0d cycles, required 0", nm, bad_d);
    else passed++;
    checks++;
    if (cmd_done !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL %s done@%0d: done=%b ready=%b busy=%b, required 1 1 0",
               nm, n, cmd_done, cmd_ready, busy);
    else passed++;
  endtask

  task automatic send(input string nm, input logic [1:0] t, input logic [3:0] ad,
                      input logic [7:0] a, input logic [7:0] b, input logic [3:0] fn,
                      input logic pe, input logic pt, input int div, input bit scr);
    @(negedge CLK);
    cmd_type = t; cmd_addr = ad; cmd_op_a = a; cmd_op_b = b; cmd_fun = fn;
    par_en = pe; par_typ = pt; baud_div = 16'(div); cmd_valid = 1'b1;
    checks++;
    if (tx_out !== 1'b1 || cmd_ready !== 1'b1)
      $display("FAIL %s pre_idle: tx=%b ready=%b, required 1 1", nm, tx_out, cmd_ready);
    else passed++;
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    check_stream(nm, t, ad, a, b, fn, pe, pt, div, scr);
    @(posedge CLK); #1;
    checks++;
    if (cmd_done !== 1'b0 || tx_out !== 1'b1)
      $display("FAIL %s post_idle: done=%b tx=%b, required 0 1", nm, cmd_done, tx_out);
    else passed++;
  endtask

  task automatic test_reset();
    #2 RST = 1'b0;
    #1;
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1 || cmd_done !== 1'b0)
      $display("FAIL reset: tx=%b busy=%b ready=%b done=%b, required 1 0 1 0",
               tx_out, busy, cmd_ready, cmd_done);
    else passed++;
    repeat (3) @(posedge CLK);
    @(negedge CLK) RST = 1'b1;
  endtask

  task automatic test_rf_write();
    send("rf_write", 2'd0, 4'h5, 8'h3C, 8'h00, 4'h0, 1'b0, 1'b0, 4, 1'b1);
  endtask

  task automatic test_parity();
    send("rf_read_even", 2'd1, 4'hA, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, 2, 1'b1);
    send("rf_read_odd",  2'd1, 4'hA, 8'h00, 8'h00, 4'h0, 1'b1, 1'b1, 2, 1'b1);
  endtask

  task automatic test_alu_op();
    send("alu_op", 2'd2, 4'h0, 8'h12, 8'h34, 4'h1, 1'b0, 1'b0, 3, 1'b1);
  endtask

  task automatic test_baud_zero();
    send("alu_nop_div0", 2'd3, 4'h0, 8'h00, 8'h00, 4'h7, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    @(negedge CLK);
    cmd_type = 2'd2; cmd_addr = 4'h0; cmd_op_a = 8'h5A; cmd_op_b = 8'hC3;
    cmd_fun = 4'h9; par_en = 1'b0; par_typ = 1'b0; baud_div = 16'd3;
    cmd_valid = 1'b1;
    @(posedge CLK); #1;
    cmd_type = 2'd1; cmd_addr = 4'h9; par_en = 1'b1; par_typ = 1'b1;
    baud_div = 16'd2;
    check_stream("b2b_first", 2'd2, 4'h0, 8'h5A, 8'hC3, 4'h9, 1'b0, 1'b0, 3, 1'b0);
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    check_stream("b2b_second", 2'd1, 4'h9, 8'h5A, 8'hC3, 4'h9, 1'b1, 1'b1, 2, 1'b0);
    @(posedge CLK); #1;
    checks++;
    if (cmd_done !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL b2b_idle: done=%b ready=%b, required 0 1", cmd_done, cmd_ready);
    else passed++;
  endtask

  task automatic test_reset_midframe();
    @(negedge CLK);
    cmd_type = 2'd0; cmd_addr = 4'h5; cmd_op_a = 8'h3C;
    par_en = 1'b0; baud_div = 16'd4; cmd_valid = 1'b1;
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    // second byte 0x05, data bit 1 (a zero) spans cycles 52..55
    repeat (53) @(posedge CLK);
    #2;
    checks++;
    if (tx_out !== 1'b0 || busy !== 1'b1)
      $display("FAIL midframe_pre: tx=%b busy=%b, required 0 1", tx_out, busy);
    else passed++;
    RST = 1'b0;
    #1;
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1 || cmd_done !== 1'b0)
      $display("FAIL midframe_reset: tx=%b busy=%b ready=%b done=%b, required 1 0 1 0",
               tx_out, busy, cmd_ready, cmd_done);
    else passed++;
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST = 1'b1;
    send("after_reset", 2'd2, 4'h0, 8'hA5, 8'h0F, 4'hE, 1'b1, 1'b0, 2, 1'b1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      send($sformatf("rand%0d", k), 2'($urandom), 4'($urandom), 8'($urandom),
           8'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
           int'($urandom_range(0, 5)), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_rf_write();
    test_parity();
    test_alu_op();
    test_baud_zero();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
